tone_gen: RTL and testbench



---
 rtl/tone_gen.sv | 169 ++++++++++++++++
 tb/tb_tone_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// tone_gen: square-wave tone synthesizer.
// Takes a frequency request in Hz over valid/ready, computes the half-period
// floor(SYS_FREQ/(2f)) with a one-bit-per-cycle restoring divider, and drives
// a 50%-duty square wave whose half-cycle is that many clocks.
// Build option: define TONE_GEN_GLITCHFREE_EN to apply new half-periods only
// at toggle boundaries; leave it undefined to apply them one edge after the
// divider finishes, restarting the waveform at phase 0.
module tone_gen #(
   parameter  int SYS_FREQ = 100000,
   parameter  int MAX_FREQ = 20000,
   parameter  int FREQ_W   = 16,
   localparam int HP_W     = $clog2(SYS_FREQ/2+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FREQ_W-1:0] freq_in,
   input  logic              freq_valid,
   output logic              freq_ready,
   output logic              tone_out,
   output logic [HP_W-1:0]   half_period,
   output logic              busy
);

   localparam int RW    = FREQ_W + 1;
   localparam int CNT_W = $clog2(HP_W + 1);
   localparam logic [HP_W-1:0]   DIVIDEND = HP_W'(SYS_FREQ/2);
   localparam logic [FREQ_W-1:0] MAX_F    = FREQ_W'(MAX_FREQ);

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [FREQ_W-1:0]  divisor_q, divisor_d;
   logic [FREQ_W-1:0]  rem_q, rem_d;
   logic [HP_W-1:0]    quot_q, quot_d;      // dividend bits shift out, quotient bits shift in
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [HP_W-1:0]    pend_q, pend_d;
   logic               pend_valid_q, pend_valid_d;
   logic [HP_W-1:0]    hp_q, hp_d;
   logic [HP_W-1:0]    cnt_q, cnt_d;
   logic               tone_q, tone_d;

   logic               accept;
   logic [FREQ_W-1:0]  f_clamped;
   logic [RW-1:0]      rem_shift;
   logic               rem_ge;
   logic [FREQ_W-1:0]  rem_sub;
   logic               done_wr;
   logic               wrap;
   logic               apply;

   assign accept    = freq_valid && (state_q == ST_IDLE);
   assign f_clamped = (freq_in > MAX_F) ? MAX_F : freq_in;
   assign rem_shift = {rem_q, quot_q[HP_W-1]};
   assign rem_ge    = rem_shift >= {1'b0, divisor_q};
   assign rem_sub   = rem_shift[FREQ_W-1:0] - divisor_q;
   assign done_wr   = (state_q == ST_DONE);
   assign wrap      = (hp_q != '0) && (cnt_q == hp_q - HP_W'(1));

`ifdef TONE_GEN_GLITCHFREE_EN
   // new half-period only lands while muted or exactly on a toggle edge
   assign apply = pend_valid_q && ((hp_q == '0) || wrap);
`else
   // new half-period lands on the first edge it is available
   assign apply = pend_valid_q;
`endif

   // divider FSM: accept, shift-subtract HP_W times, publish quotient
   always_comb begin
      state_d   = state_q;
      divisor_d = divisor_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               divisor_d = f_clamped;
               rem_d     = '0;
               bit_cnt_d = '0;
               if (f_clamped == '0) begin
                  quot_d  = '0;          // mute skips the divider
                  state_d = ST_DONE;
               end else begin
                  quot_d  = DIVIDEND;
                  state_d = ST_DIV;
               end
            end
         end
         ST_DIV: begin
            rem_d     = rem_ge ? rem_sub : rem_shift[FREQ_W-1:0];
            quot_d    = {quot_q[HP_W-2:0], rem_ge};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(HP_W-1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // pending slot: divider result waits here until the tone counter takes it
   always_comb begin
      pend_d       = done_wr ? quot_q : pend_q;
      pend_valid_d = pend_valid_q;
      if (apply)   pend_valid_d = 1'b0;
      if (done_wr) pend_valid_d = 1'b1;   // a fresh result outranks one just consumed
   end

   // tone counter: toggle every hp_q cycles, hold low while muted
   always_comb begin
      hp_d   = hp_q;
      cnt_d  = cnt_q;
      tone_d = tone_q;
      if (hp_q == '0) begin
         cnt_d  = '0;
         tone_d = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         tone_d = ~tone_q;
      end else begin
         cnt_d  = cnt_q + HP_W'(1);
      end
      if (apply) begin
         hp_d = pend_q;
`ifdef TONE_GEN_GLITCHFREE_EN
         if (pend_q == '0) tone_d = 1'b0;
`else
         cnt_d  = '0;
         tone_d = 1'b0;
`endif
      end
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         divisor_q    <= '0;
         rem_q        <= '0;
         quot_q       <= '0;
         bit_cnt_q    <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         hp_q         <= '0;
         cnt_q        <= '0;
         tone_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         divisor_q    <= divisor_d;
         rem_q        <= rem_d;
         quot_q       <= quot_d;
         bit_cnt_q    <= bit_cnt_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         hp_q         <= hp_d;
         cnt_q        <= cnt_d;
         tone_q       <= tone_d;
      end
   end

   // simulation check: a nonzero request must never produce a zero half-period
   assert property (@(posedge clk) disable iff (!reset)
                    (done_wr && divisor_q != '0) |-> (quot_q != '0));

   assign freq_ready  = (state_q == ST_IDLE);
   assign tone_out    = tone_q;
   assign half_period = hp_q;
   assign busy        = (state_q != ST_IDLE) | pend_valid_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed scenarios for tone_gen with hand-computed timing.
module tb_tone_gen;

`ifdef TONE_GEN_GLITCHFREE_EN
   localparam bit GF = 1'b1;
`else
   localparam bit GF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] freq_in = '0;
   logic        freq_valid = 1'b0;
   logic        freq_ready;
   logic        tone_out;
   logic [15:0] half_period;
   logic        busy;

   int errors = 0;
   int checks = 0;

   tone_gen dut (
      .clk         (clk),
      .reset       (rst_n),
      .freq_in     (freq_in),
      .freq_valid  (freq_valid),
      .freq_ready  (freq_ready),
      .tone_out    (tone_out),
      .half_period (half_period),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int f);
      int w;
      w = 0;
      while (!freq_ready && w < 100) begin
         tick();
         w++;
      end
      freq_in    = 16'(f);
      freq_valid = 1'b1;
      tick();
      freq_valid = 1'b0;
      $display("req freq=%0d at t=%0t", f, $time);
   endtask

   task automatic wait_tone(input logic level, output int n);
      n = 0;
      while (tone_out !== level && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_hp(input int v, output bit ok);
      int n;
      n = 0;
      while (half_period !== 16'(v) && n < 2000) begin
         tick();
         n++;
      end
      ok = (half_period === 16'(v));
   endtask

   task automatic count_ready_low(output int n);
      n = 0;
      while (!freq_ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (freq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", freq_ready); end
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL reset_tone got=%b exp=0", tone_out); end
      checks++; if (half_period !== 16'd0) begin errors++; $display("FAIL reset_hp got=%0d exp=0", half_period); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      send(1000);
      count_ready_low(n);
      checks++; if (n !== 17) begin errors++; $display("FAIL basic_ready_low got=%0d exp=17", n); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_pending got=%b exp=1", busy); end
      tick();
      checks++; if (half_period !== 16'd50) begin errors++; $display("FAIL basic_hp got=%0d exp=50", half_period); end
      wait_tone(1'b1, n);
      checks++; if (n !== 50) begin errors++; $display("FAIL basic_first_rise got=%0d exp=50", n); end
      wait_tone(1'b0, n);
      checks++; if (n !== 50) begin errors++; $display("FAIL basic_high got=%0d exp=50", n); end
      wait_tone(1'b1, n);
      checks++; if (n !== 50) begin errors++; $display("FAIL basic_low got=%0d exp=50", n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
      wait_tone(1'b0, n);
   endtask

   task automatic test_change();
      int n, hi_len, exp_hi;
      exp_hi = GF ? 50 : 29;
      wait_tone(1'b1, n);
      repeat (10) tick();
      send(250);
      wait_tone(1'b0, n);
      hi_len = 11 + n;
      checks++; if (hi_len !== exp_hi) begin errors++; $display("FAIL change_last_high got=%0d exp=%0d", hi_len, exp_hi); end
      checks++; if (half_period !== 16'd200) begin errors++; $display("FAIL change_hp got=%0d exp=200", half_period); end
      wait_tone(1'b1, n);
      checks++; if (n !== 200) begin errors++; $display("FAIL change_low got=%0d exp=200", n); end
      wait_tone(1'b0, n);
      checks++; if (n !== 200) begin errors++; $display("FAIL change_high got=%0d exp=200", n); end
   endtask

   task automatic test_clamp();
      int n;
      bit ok;
      send(30000);
      wait_hp(2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_hp got=%0d exp=2", half_period); end
      wait_tone(1'b1, n);
      wait_tone(1'b0, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL clamp_high got=%0d exp=2", n); end
      wait_tone(1'b1, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL clamp_low got=%0d exp=2", n); end
   endtask

   task automatic test_mute();
      int n;
      bit ok;
      bit seen_high;
      send(0);
      count_ready_low(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL mute_ready_low got=%0d exp=1", n); end
      wait_hp(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mute_hp got=%0d exp=0", half_period); end
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL mute_tone got=%b exp=0", tone_out); end
      seen_high = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tone_out !== 1'b0) seen_high = 1'b1;
      end
      checks++; if (seen_high !== 1'b0) begin errors++; $display("FAIL mute_stays_low got=%b exp=0", seen_high); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mute_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int n;
      bit ok;
      bit saw_500;
      bit exp_saw;
      exp_saw = GF ? 1'b0 : 1'b1;
      send(1000);
      wait_hp(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_start_hp got=%0d exp=50", half_period); end
      saw_500 = 1'b0;
      send(500);
      n = 0;
      while (!freq_ready && n < 100) begin
         tick();
         n++;
         if (half_period === 16'd100) saw_500 = 1'b1;
      end
      freq_in    = 16'd2000;
      freq_valid = 1'b1;
      tick();
      freq_valid = 1'b0;
      $display("req freq=2000 at t=%0t", $time);
      if (half_period === 16'd100) saw_500 = 1'b1;
      n = 0;
      while (half_period !== 16'd25 && n < 200) begin
         tick();
         n++;
         if (half_period === 16'd100) saw_500 = 1'b1;
      end
      checks++; if (half_period !== 16'd25) begin errors++; $display("FAIL b2b_final_hp got=%0d exp=25", half_period); end
      checks++; if (saw_500 !== exp_saw) begin errors++; $display("FAIL b2b_saw_500 got=%b exp=%b", saw_500, exp_saw); end
      wait_tone(1'b1, n);
      wait_tone(1'b0, n);
      checks++; if (n !== 25) begin errors++; $display("FAIL b2b_high got=%0d exp=25", n); end
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok;
      send(1000);
      repeat (7) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (freq_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", freq_ready); end
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL rmid_tone got=%b exp=0", tone_out); end
      checks++; if (half_period !== 16'd0) begin errors++; $display("FAIL rmid_hp got=%0d exp=0", half_period); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      #1 rst_n = 1'b1;
      tick();
      send(1000);
      count_ready_low(n);
      checks++; if (n !== 17) begin errors++; $display("FAIL rmid_ready_low got=%0d exp=17", n); end
      wait_hp(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_hp_after got=%0d exp=50", half_period); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_change();
      test_clamp();
      test_mute();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
